// File: rtl/secded_pkg.sv
// Shared definitions for the Hamming(7,4)+P SECDED link.
`timescale 1ns/1ps
package secded_pkg;

   localparam int CW_W   = 8;
   localparam int DATA_W = 4;

   localparam int B_P1 = 0;
   localparam int B_P2 = 1;
   localparam int B_D1 = 2;
   localparam int B_P3 = 3;
   localparam int B_D2 = 4;
   localparam int B_D3 = 5;
   localparam int B_D4 = 6;
   localparam int B_P  = 7;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      DOUBLE,
      PARITY
   } err_class_e;

endpackage

// File: rtl/secded_decode_comb.sv
// Combinational SECDED decoder: syndrome, error class, corrected data.
`timescale 1ns/1ps
module secded_decode_comb
   import secded_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [DATA_W-1:0] data_o,
   output logic [2:0]        syndrome_o,
   output err_class_e        class_o
);

   logic [2:0]      s;
   logic            p;
   logic            fix;
   logic [CW_W-1:0] c;

   always_comb begin
      s[0] = cw_i[B_P1] ^ cw_i[B_D1] ^ cw_i[B_D2] ^ cw_i[B_D4];
      s[1] = cw_i[B_P2] ^ cw_i[B_D1] ^ cw_i[B_D3] ^ cw_i[B_D4];
      s[2] = cw_i[B_P3] ^ cw_i[B_D2] ^ cw_i[B_D3] ^ cw_i[B_D4];
      p    = ^cw_i;
      fix  = (s != 3'd0) && p;
      c    = cw_i;
      // syndrome names the 1-based Hamming position to flip
      for (int i = 0; i < 7; i++) begin
         if (fix && (s == 3'(i + 1))) c[i] = ~cw_i[i];
      end
      data_o     = {c[B_D4], c[B_D3], c[B_D2], c[B_D1]};
      syndrome_o = s;
      unique case (1'b1)
         (s != 3'd0) &&  p: class_o = SINGLE;
         (s != 3'd0) && !p: class_o = DOUBLE;
         (s == 3'd0) &&  p: class_o = PARITY;
         default:           class_o = NONE;
      endcase
   end

endmodule

// File: rtl/hamming_secded_rx.sv
// Serial SECDED receiver: deserializer FSM, one-entry output buffer,
// saturating error counters.
`timescale 1ns/1ps
module hamming_secded_rx
   import secded_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_line,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [3:0]       o_data,
   output logic [2:0]       o_syndrome,
   output logic             o_1bit_error,
   output logic             o_2bit_error,
   output logic             o_parity_error,
   output logic             o_frame_error,
   output logic             o_overrun,
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_cnt_1bit,
   output logic [CNT_W-1:0] o_cnt_2bit,
   output logic [CNT_W-1:0] o_cnt_par
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_e;

   state_e          state_q;
   logic [2:0]      bitcnt_q;
   logic [CW_W-1:0] sr_q;
   logic            ferr_q;

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        syn_q;
   logic              e1_q;
   logic              e2_q;
   logic              ep_q;
   logic              ovr_q;

   logic [CNT_W-1:0] c1_q, c1_d;
   logic [CNT_W-1:0] c2_q, c2_d;
   logic [CNT_W-1:0] cp_q, cp_d;

   logic [DATA_W-1:0] dec_data;
   logic [2:0]        dec_syn;
   err_class_e        dec_cls;

   logic frame_ok;
   logic accept;
   logic drop;

   secded_decode_comb u_dec (
      .cw_i       (sr_q),
      .data_o     (dec_data),
      .syndrome_o (dec_syn),
      .class_o    (dec_cls)
   );

   assign frame_ok = i_tick && (state_q == S_STOP) && i_line;
   assign accept   = frame_ok && (!valid_q || i_ready);
   assign drop     = frame_ok && valid_q && !i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         bitcnt_q <= 3'd0;
         sr_q     <= '0;
         ferr_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         if (i_tick) begin
            unique case (state_q)
               S_IDLE: begin
                  if (!i_line) begin
                     state_q  <= S_DATA;
                     bitcnt_q <= 3'd0;
                  end
               end
               S_DATA: begin
                  sr_q[bitcnt_q] <= i_line;
                  bitcnt_q       <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_q <= S_STOP;
               end
               S_STOP: begin
                  if (i_line) begin
                     state_q <= S_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (i_line) state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         syn_q   <= 3'd0;
         e1_q    <= 1'b0;
         e2_q    <= 1'b0;
         ep_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= drop;
         if (accept) begin
            valid_q <= 1'b1;
            data_q  <= dec_data;
            syn_q   <= dec_syn;
            e1_q    <= (dec_cls == SINGLE);
            e2_q    <= (dec_cls == DOUBLE);
            ep_q    <= (dec_cls == PARITY);
         end else if (i_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   function automatic logic [CNT_W-1:0] bump(
      input logic [CNT_W-1:0] c,
      input logic             hit
   );
      return (hit && (c != '1)) ? c + CNT_W'(1) : c;
   endfunction

   always_comb begin
      c1_d = bump(c1_q, accept && (dec_cls == SINGLE));
      c2_d = bump(c2_q, accept && (dec_cls == DOUBLE));
      cp_d = bump(cp_q, accept && (dec_cls == PARITY));
      if (i_cnt_clr) begin
         c1_d = '0;
         c2_d = '0;
         cp_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c1_q <= '0;
         c2_q <= '0;
         cp_q <= '0;
      end else begin
         c1_q <= c1_d;
         c2_q <= c2_d;
         cp_q <= cp_d;
      end
   end

   assign o_valid        = valid_q;
   assign o_data         = data_q;
   assign o_syndrome     = syn_q;
   assign o_1bit_error   = e1_q;
   assign o_2bit_error   = e2_q;
   assign o_parity_error = ep_q;
   assign o_frame_error  = ferr_q;
   assign o_overrun      = ovr_q;
   assign o_cnt_1bit     = c1_q;
   assign o_cnt_2bit     = c2_q;
   assign o_cnt_par      = cp_q;

endmodule

// File: doc/hamming_secded_rx.md
Name: hamming_secded_rx

Overview:
- Serial receiving end of the Hamming(7,4)+overall-parity SECDED link.
- Deserializes 8-bit codewords from a single-bit line, then decodes and corrects them.
- Presents the 4-bit data word and error flags through a valid/ready output buffer.
- Keeps saturating error-statistics counters for link-quality monitoring.

Parameters:
- CNT_W, 8, width of each saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_tick  in  1  bit-sample strobe; the line is sampled only on cycles where i_tick=1.
- i_line  in  1  serial input; idles high.
- o_valid  out  1  decoded word available in the output buffer.
- i_ready  in  1  consumer accepts the word when o_valid&i_ready.
- o_data  out  4  corrected data {d4,d3,d2,d1}.
- o_syndrome  out  3  {s3,s2,s1} of the buffered word.
- o_1bit_error  out  1  single error corrected (s!=0, p=1).
- o_2bit_error  out  1  uncorrectable double error (s!=0, p=0); o_data is then raw, uncorrected.
- o_parity_error  out  1  only the overall parity bit is wrong (s=0, p=1).
- o_frame_error  out  1  one-cycle pulse: stop bit sampled 0.
- o_overrun  out  1  one-cycle pulse: frame completed while the buffer was full.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_cnt_1bit  out  CNT_W  count of corrected frames.
- o_cnt_2bit  out  CNT_W  count of uncorrectable frames.
- o_cnt_par  out  CNT_W  count of parity-only frames.

Behaviour:
- Codeword cw[7:0]:
  - cw[i] is Hamming position i+1 for i=0..6: p1,p2,d1,p3,d2,d3,d4.
  - cw[7] is even parity over cw[6:0].
- Frame format: start bit 0, then cw[0]..cw[7] LSB first, then stop bit 1. One bit per i_tick.
- FSM states:
  - IDLE: on tick with i_line=0, go to DATA with bitcnt=0.
  - DATA: on each tick, shift i_line into cw[bitcnt]. After bitcnt=7, go to STOP.
  - STOP: on tick with i_line=1, decode the frame and go to IDLE. On tick with i_line=0, pulse o_frame_error, discard the frame, go to WAIT_IDLE.
  - WAIT_IDLE: on tick with i_line=1, go to IDLE.
- Non-tick cycles: hold state and data.
- Decode:
  - s1 = cw0^cw2^cw4^cw6; s2 = cw1^cw2^cw5^cw6; s3 = cw3^cw4^cw5^cw6.
  - p = ^cw[7:0].
  - If s!=0 and p=1, flip bit position s (cw[s-1]) before extracting data.
  - data = {cw6,cw5,cw4,cw2}.
- Latency: o_valid and all sideband outputs are registered. They assert the cycle after the stop-bit tick.
- Output buffer (one entry):
  - Filled on a good stop bit when empty, or when it drains in the same cycle (o_valid&i_ready). In that case the new word replaces the old one with no bubble.
  - If full and not draining, the new frame is dropped, o_overrun pulses, and counters are not updated.
  - o_data and the flags are stable while o_valid=1 and i_ready=0.
- Counters:
  - Increment on each frame accepted into the buffer with the matching flag.
  - Saturate at all-ones.
  - i_cnt_clr has priority over an increment in the same cycle.
  - Framing-error and overrun frames are never counted.
- Reset:
  - State IDLE, bitcnt 0, shift register 0.
  - o_valid=0; o_data, o_syndrome and all flags 0; pulses 0; counters 0.
  - Reset mid-frame abandons the frame with no output.
- A start bit can be detected on the tick immediately after a good stop bit; back-to-back frames are supported.

Decomposition:
- Shared package secded_pkg holds:
  - CW_W=8 and DATA_W=4.
  - Bit-index constants for p1,p2,d1,p3,d2,d3,d4,P.
  - An error-class enum: NONE, SINGLE, DOUBLE, PARITY.
- One combinational sub-module, secded_decode_comb: cw[7:0] in; data, syndrome and class out. It is reusable by other SECDED consumers.
- The FSM, output buffer and counters stay in the top.

Test Plan:
- Clean frame cw=8'h55 (data 4'b1011), i_ready=1 -> one o_valid cycle, o_data=4'hB, syndrome 0, all flags 0, counters unchanged.
- cw=8'h45 (cw[4] flipped) -> o_data=4'hB, o_syndrome=3'd5, o_1bit_error=1, o_cnt_1bit=1.
- cw=8'h44 (cw[4] and cw[0] flipped) -> o_syndrome=3'd4, o_2bit_error=1, o_cnt_2bit=1. cw=8'hD5 -> o_syndrome=0, o_parity_error=1, o_data=4'hB, o_cnt_par=1.
- Frame 8'h55 with stop bit 0 -> o_frame_error pulse, no o_valid. The FSM stays in WAIT_IDLE while the line is low, then a following good frame decodes normally.
- Two back-to-back frames (8'h55 then 8'h45) with i_ready=0 -> first word held stable, second dropped with o_overrun pulse and o_cnt_1bit=0. Raising i_ready -> one transfer of 4'hB.
- Counter saturation with CNT_W=2: four corrected frames -> o_cnt_1bit=3. i_cnt_clr asserted together with an increment -> counter reads 0.
